// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler: per-warp PC / split-table store with round-robin issue
// of one pc_info_t per cycle towards the instruction fetch unit.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rdy                  global enable; all state holds while low
//   launch_*             dispatcher starts a warp at launch_pc
//   upd_*                later-stage resume (new pc/split) or retire (upd_exit)
//   dout_valid/ready     valid/ready handshake to fetch, payload dout
//   warp_active          per-warp active mask
//   all_idle             no warp active and nothing held in dout
package gelato_fetch_scheduler_pkg;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned WARP_W  = 2;
  localparam int unsigned SPLIT_W = 2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [WARP_W-1:0]  warp_num;
    logic [SPLIT_W-1:0] split_table_num;
  } pc_info_t;
endpackage

module gelato_fetch_scheduler
  import gelato_fetch_scheduler_pkg::*;
#(
  parameter int NUM_WARPS       = 4,
  parameter int WARP_NUM_WIDTH  = $clog2(NUM_WARPS),
  parameter int SPLIT_NUM_WIDTH = 2,
  parameter int PC_WIDTH        = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       launch_valid,
  input  logic [WARP_NUM_WIDTH-1:0]  launch_warp,
  input  logic [PC_WIDTH-1:0]        launch_pc,
  input  logic                       upd_valid,
  input  logic [WARP_NUM_WIDTH-1:0]  upd_warp,
  input  logic [PC_WIDTH-1:0]        upd_pc,
  input  logic [SPLIT_NUM_WIDTH-1:0] upd_split_table_num,
  input  logic                       upd_exit,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output pc_info_t                   dout,
  output logic [NUM_WARPS-1:0]       warp_active,
  output logic                       all_idle
);

  logic [NUM_WARPS-1:0]       active_q, active_d;
  logic [NUM_WARPS-1:0]       pending_q, pending_d;
  logic [PC_WIDTH-1:0]        pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]        pc_d [NUM_WARPS];
  logic [SPLIT_NUM_WIDTH-1:0] split_q [NUM_WARPS];
  logic [SPLIT_NUM_WIDTH-1:0] split_d [NUM_WARPS];
  logic [WARP_NUM_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                       dout_valid_q, dout_valid_d;
  pc_info_t                   dout_q, dout_d;
  logic                       all_idle_q, all_idle_d;

  logic [NUM_WARPS-1:0]       eligible;
  logic                       win_found;
  logic [WARP_NUM_WIDTH-1:0]  win_idx;
  logic [WARP_NUM_WIDTH-1:0]  cand;
  logic                       load;
  logic                       launch_ok;
  logic                       upd_ok;

  assign eligible = active_q & ~pending_q;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = rr_ptr_q + WARP_NUM_WIDTH'(i);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign load      = (~dout_valid_q | dout_ready) & win_found;
  // A same-cycle update to the launched warp takes priority over the launch.
  assign launch_ok = launch_valid & ~active_q[launch_warp]
                   & ~(upd_valid & (upd_warp == launch_warp));
  assign upd_ok    = upd_valid & active_q[upd_warp] & pending_q[upd_warp];

  // Next-state for warp table, output register and arbiter pointer.
  always_comb begin
    active_d     = active_q;
    pending_d    = pending_q;
    pc_d         = pc_q;
    split_d      = split_q;
    rr_ptr_d     = rr_ptr_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;

    if (load) begin
      dout_d.pc              = PC_W'(pc_q[win_idx]);
      dout_d.warp_num        = WARP_W'(win_idx);
      dout_d.split_table_num = SPLIT_W'(split_q[win_idx]);
      dout_valid_d           = 1'b1;
      pending_d[win_idx]     = 1'b1;
      rr_ptr_d               = win_idx;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    if (launch_ok) begin
      active_d[launch_warp]  = 1'b1;
      pending_d[launch_warp] = 1'b0;
      pc_d[launch_warp]      = launch_pc;
      split_d[launch_warp]   = '0;
    end

    if (upd_ok) begin
      pending_d[upd_warp] = 1'b0;
      if (upd_exit) begin
        active_d[upd_warp] = 1'b0;
      end else begin
        pc_d[upd_warp]    = upd_pc;
        split_d[upd_warp] = upd_split_table_num;
      end
    end

    all_idle_d = ~|active_d & ~dout_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= '0;
      pending_q    <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]    <= '0;
        split_q[w] <= '0;
      end
      rr_ptr_q     <= WARP_NUM_WIDTH'(NUM_WARPS - 1);
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      all_idle_q   <= 1'b1;
    end else if (rdy) begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pc_q         <= pc_d;
      split_q      <= split_d;
      rr_ptr_q     <= rr_ptr_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      all_idle_q   <= all_idle_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout        = dout_q;
  assign warp_active = active_q;
  assign all_idle    = all_idle_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Self-checking bench for gelato_fetch_scheduler: expected pc_info words are
// queued as stimulus is driven and compared on every accepted transfer.
module tb_gelato_fetch_scheduler;
  import gelato_fetch_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        launch_valid = 1'b0;
  logic [1:0]  launch_warp = '0;
  logic [31:0] launch_pc = '0;
  logic        upd_valid = 1'b0;
  logic [1:0]  upd_warp = '0;
  logic [31:0] upd_pc = '0;
  logic [1:0]  upd_split_table_num = '0;
  logic        upd_exit = 1'b0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  pc_info_t    dout;
  logic [3:0]  warp_active;
  logic        all_idle;

  int n_cmp = 0;
  int n_bad = 0;
  pc_info_t exp_q [$];

  gelato_fetch_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
    .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_pc(upd_pc),
    .upd_split_table_num(upd_split_table_num), .upd_exit(upd_exit),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .warp_active(warp_active), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pc_info_t mk(input logic [31:0] pc, input logic [1:0] w, input logic [1:0] s);
    pc_info_t p;
    p.pc = pc;
    p.warp_num = w;
    p.split_table_num = s;
    return p;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_launch(input logic [1:0] w, input logic [31:0] pc);
    launch_valid = 1'b1; launch_warp = w; launch_pc = pc;
    tick(1);
    launch_valid = 1'b0;
  endtask

  task automatic do_upd(input logic [1:0] w, input logic [31:0] pc,
                        input logic [1:0] s, input logic ex);
    upd_valid = 1'b1; upd_warp = w; upd_pc = pc; upd_split_table_num = s; upd_exit = ex;
    tick(1);
    upd_valid = 1'b0; upd_exit = 1'b0;
  endtask

  // Scoreboard: every transfer that will be accepted at the next edge is compared.
  always @(negedge clk) begin
    if (rst_n && rdy && dout_valid && dout_ready) begin
      check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check_eq("sb_dout", 64'(dout), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_valid", 64'(dout_valid), 64'd0);
    check_eq("rst_dout", 64'(dout), 64'd0);
    check_eq("rst_active", 64'(warp_active), 64'd0);
    check_eq("rst_idle", 64'(all_idle), 64'd1);
    rst_n = 1'b1;
    tick(1);
    dout_ready = 1'b1;

    // Single launch: valid rises on the second edge.
    exp_q.push_back(mk(32'h100, 2'd2, 2'd0));
    do_launch(2'd2, 32'h100);
    check_eq("l2_valid_e1", 64'(dout_valid), 64'd0);
    check_eq("l2_active", 64'(warp_active), 64'b0100);
    check_eq("l2_idle", 64'(all_idle), 64'd0);
    tick(1);
    check_eq("l2_valid_e2", 64'(dout_valid), 64'd1);
    check_eq("l2_dout", 64'(dout), 64'(mk(32'h100, 2'd2, 2'd0)));
    tick(1);
    check_eq("l2_drop", 64'(dout_valid), 64'd0);
    do_upd(2'd2, 32'h0, 2'd0, 1'b1);
    check_eq("x2_active", 64'(warp_active), 64'd0);
    check_eq("x2_idle", 64'(all_idle), 64'd1);

    // Four warps, one issue per cycle in order 0..3, then a resume of warp 1.
    for (int w = 0; w < 4; w++) exp_q.push_back(mk(32'(w * 16), 2'(w), 2'd0));
    for (int w = 0; w < 4; w++) do_launch(2'(w), 32'(w * 16));
    tick(1);
    check_eq("rr_dout3", 64'(dout), 64'(mk(32'h30, 2'd3, 2'd0)));
    tick(1);
    check_eq("rr_drained", 64'(dout_valid), 64'd0);
    check_eq("rr_active", 64'(warp_active), 64'b1111);
    exp_q.push_back(mk(32'h14, 2'd1, 2'd1));
    do_upd(2'd1, 32'h14, 2'd1, 1'b0);
    tick(1);
    check_eq("u1_dout", 64'(dout), 64'(mk(32'h14, 2'd1, 2'd1)));
    tick(1);

    // Backpressure: warp 0 held, warp 3 waits, then issues right behind it.
    dout_ready = 1'b0;
    exp_q.push_back(mk(32'h8, 2'd0, 2'd0));
    exp_q.push_back(mk(32'h34, 2'd3, 2'd2));
    do_upd(2'd0, 32'h8, 2'd0, 1'b0);
    do_upd(2'd3, 32'h34, 2'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_valid", 64'(dout_valid), 64'd1);
      check_eq("bp_dout", 64'(dout), 64'(mk(32'h8, 2'd0, 2'd0)));
      tick(1);
    end
    dout_ready = 1'b1;
    tick(1);
    check_eq("bp_w3", 64'(dout), 64'(mk(32'h34, 2'd3, 2'd2)));
    tick(1);

    // Retire a pending warp; it must never come back.
    do_upd(2'd0, 32'h0, 2'd0, 1'b1);
    check_eq("x0_active", 64'(warp_active), 64'b1110);
    tick(3);
    check_eq("x0_noissue", 64'(dout_valid), 64'd0);
    check_eq("x0_idle", 64'(all_idle), 64'd0);

    // Ignored events while dout is stalled.
    dout_ready = 1'b0;
    exp_q.push_back(mk(32'h38, 2'd3, 2'd0));
    exp_q.push_back(mk(32'h40, 2'd1, 2'd0));
    exp_q.push_back(mk(32'h24, 2'd2, 2'd3));
    do_upd(2'd3, 32'h38, 2'd0, 1'b0);
    do_upd(2'd1, 32'h40, 2'd0, 1'b0);
    do_launch(2'd1, 32'hdead);
    do_upd(2'd1, 32'h77, 2'd2, 1'b0);
    do_upd(2'd0, 32'hbeef, 2'd1, 1'b0);
    check_eq("ign_active", 64'(warp_active), 64'b1110);
    launch_valid = 1'b1; launch_warp = 2'd2; launch_pc = 32'h999;
    do_upd(2'd2, 32'h24, 2'd3, 1'b0);
    launch_valid = 1'b0;
    check_eq("ign_hold", 64'(dout), 64'(mk(32'h38, 2'd3, 2'd0)));
    dout_ready = 1'b1;
    tick(3);
    check_eq("ign_drained", 64'(dout_valid), 64'd0);

    // Global enable low: nothing moves, even an exit request.
    do_upd(2'd2, 32'h50, 2'd0, 1'b0);
    rdy = 1'b0;
    upd_valid = 1'b1; upd_warp = 2'd1; upd_exit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_eq("rdy_valid", 64'(dout_valid), 64'd0);
      check_eq("rdy_active", 64'(warp_active), 64'b1110);
    end
    upd_valid = 1'b0; upd_exit = 1'b0;
    rdy = 1'b1;
    exp_q.push_back(mk(32'h50, 2'd2, 2'd0));
    tick(1);
    check_eq("rdy_issue", 64'(dout), 64'(mk(32'h50, 2'd2, 2'd0)));
    tick(1);

    // Asynchronous reset with a word held in dout.
    dout_ready = 1'b0;
    do_upd(2'd3, 32'h60, 2'd1, 1'b0);
    tick(1);
    check_eq("mr_held", 64'(dout_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", 64'(dout_valid), 64'd0);
    check_eq("mr_dout", 64'(dout), 64'd0);
    check_eq("mr_active", 64'(warp_active), 64'd0);
    check_eq("mr_idle", 64'(all_idle), 64'd1);
    tick(1);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick(1);

    // Life after reset: launch, issue, retire, idle.
    exp_q.push_back(mk(32'h70, 2'd1, 2'd0));
    do_launch(2'd1, 32'h70);
    tick(2);
    check_eq("pr_drained", 64'(dout_valid), 64'd0);
    do_upd(2'd1, 32'h0, 2'd0, 1'b1);
    check_eq("pr_active", 64'(warp_active), 64'd0);
    check_eq("pr_idle", 64'(all_idle), 64'd1);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
